// File: rtl/pe_mac_dbuf.sv
// Systolic-array PE: double-buffered weight (shadow/active), signed/unsigned MAC with
// optional saturation and an optional product register stage.
module pe_mac_dbuf #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int PIPE       = 0
) (
  input  logic                  PE_clk,
  input  logic                  PE_rst_n,
  input  logic                  PE_mode_signed,
  input  logic                  PE_sat_en,
  input  logic                  PE_clr,
  input  logic                  PE_w_en,
  input  logic [DATA_WIDTH-1:0] PE_w_in,
  input  logic                  PE_w_swap,
  output logic                  PE_w_out_en,
  output logic [DATA_WIDTH-1:0] PE_w_out,
  output logic                  PE_w_ready,
  output logic                  PE_w_err,
  input  logic                  PE_act_en,
  input  logic [DATA_WIDTH-1:0] PE_act_in,
  output logic                  PE_act_out_en,
  output logic [DATA_WIDTH-1:0] PE_act_out,
  input  logic                  PE_psum_en,
  input  logic [ACC_WIDTH-1:0]  PE_psum_in,
  output logic                  PE_psum_out_en,
  output logic [ACC_WIDTH-1:0]  PE_psum_out,
  output logic                  PE_ovf
);

  // All streams are valid-only: data is captured on any edge where its _en is high,
  // there is no back-pressure, and an output _en is a single-cycle pulse per item.

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_READY = 1'b1
  } wbuf_state_e;

  wbuf_state_e           wstate_q;
  logic [DATA_WIDTH-1:0] shadow_q;
  logic [DATA_WIDTH-1:0] active_q;
  logic [DATA_WIDTH-1:0] w_out_q;
  logic                  w_out_en_q;
  logic                  w_err_q;

  always_ff @(posedge PE_clk) begin
    if (!PE_rst_n) begin
      wstate_q   <= WB_EMPTY;
      shadow_q   <= '0;
      active_q   <= '0;
      w_out_q    <= '0;
      w_out_en_q <= 1'b0;
      w_err_q    <= 1'b0;
    end else begin
      w_err_q    <= 1'b0;
      w_out_en_q <= PE_w_en;
      if (PE_w_en) begin
        shadow_q <= PE_w_in;
        w_out_q  <= shadow_q;
      end
      case (wstate_q)
        WB_EMPTY: begin
          if (PE_w_swap) w_err_q <= 1'b1;
          if (PE_w_en) wstate_q <= WB_READY;
        end
        WB_READY: begin
          // Swap takes the pre-load shadow; a concurrent load keeps the buffer full.
          if (PE_w_swap) begin
            active_q <= shadow_q;
            if (!PE_w_en) wstate_q <= WB_EMPTY;
          end
        end
        default: wstate_q <= WB_EMPTY;
      endcase
    end
  end

  assign PE_w_out_en = w_out_en_q;
  assign PE_w_out    = w_out_q;
  assign PE_w_ready  = (wstate_q == WB_READY);
  assign PE_w_err    = w_err_q;

  logic                  act_out_en_q;
  logic [DATA_WIDTH-1:0] act_out_q;

  always_ff @(posedge PE_clk) begin
    if (!PE_rst_n) begin
      act_out_en_q <= 1'b0;
      act_out_q    <= '0;
    end else begin
      act_out_en_q <= PE_act_en;
      if (PE_act_en) act_out_q <= PE_act_in;
    end
  end

  assign PE_act_out_en = act_out_en_q;
  assign PE_act_out    = act_out_q;

  // One PW-bit multiplier serves both modes: operands are extended per mode first.
  logic [PW-1:0]        act_x;
  logic [PW-1:0]        w_x;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] add_in;

  assign act_x    = PE_mode_signed ? PW'($signed(PE_act_in)) : PW'(PE_act_in);
  assign w_x      = PE_mode_signed ? PW'($signed(active_q)) : PW'(active_q);
  assign prod     = act_x * w_x;
  assign prod_ext = PE_mode_signed ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
  assign add_in   = PE_psum_en ? PE_psum_in : '0;

  logic [ACC_WIDTH-1:0] s_prod;
  logic [ACC_WIDTH-1:0] s_add;
  logic                 s_en;
  logic                 s_sgn;
  logic                 s_sat;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [ACC_WIDTH-1:0] st1_prod_q;
      logic [ACC_WIDTH-1:0] st1_add_q;
      logic                 st1_en_q;
      logic                 st1_sgn_q;
      logic                 st1_sat_q;

      always_ff @(posedge PE_clk) begin
        if (!PE_rst_n) begin
          st1_prod_q <= '0;
          st1_add_q  <= '0;
          st1_en_q   <= 1'b0;
          st1_sgn_q  <= 1'b0;
          st1_sat_q  <= 1'b0;
        end else begin
          st1_en_q  <= PE_act_en;
          st1_sgn_q <= PE_mode_signed;
          st1_sat_q <= PE_sat_en;
          if (PE_act_en) begin
            st1_prod_q <= prod_ext;
            st1_add_q  <= add_in;
          end
        end
      end

      assign s_prod = st1_prod_q;
      assign s_add  = st1_add_q;
      assign s_en   = st1_en_q;
      assign s_sgn  = st1_sgn_q;
      assign s_sat  = st1_sat_q;
    end else begin : g_direct
      assign s_prod = prod_ext;
      assign s_add  = add_in;
      assign s_en   = PE_act_en;
      assign s_sgn  = PE_mode_signed;
      assign s_sat  = PE_sat_en;
    end
  endgenerate

  logic [ACC_WIDTH:0]   sum_full;
  logic                 carry_out;
  logic                 carry_msb;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [ACC_WIDTH-1:0] result;

  assign sum_full  = {1'b0, s_prod} + {1'b0, s_add};
  assign carry_out = sum_full[ACC_WIDTH];
  assign carry_msb = s_prod[ACC_WIDTH-1] ^ s_add[ACC_WIDTH-1] ^ sum_full[ACC_WIDTH-1];
  assign ovf       = s_sgn ? (carry_out ^ carry_msb) : carry_out;
  // Signed overflow only happens with like-signed operands, so either sign picks the clamp.
  assign sat_val   = s_sgn ? (s_prod[ACC_WIDTH-1] ? SMIN : SMAX) : '1;
  assign result    = (ovf && s_sat) ? sat_val : sum_full[ACC_WIDTH-1:0];

  logic                 psum_out_en_q;
  logic [ACC_WIDTH-1:0] psum_out_q;
  logic                 ovf_q;

  always_ff @(posedge PE_clk) begin
    if (!PE_rst_n) begin
      psum_out_en_q <= 1'b0;
      psum_out_q    <= '0;
      ovf_q         <= 1'b0;
    end else begin
      psum_out_en_q <= s_en;
      if (s_en) psum_out_q <= result;
      if (s_en && ovf) ovf_q <= 1'b1;
      else if (PE_clr) ovf_q <= 1'b0;
    end
  end

  assign PE_psum_out_en = psum_out_en_q;
  assign PE_psum_out    = psum_out_q;
  assign PE_ovf         = ovf_q;

endmodule

// File: tb/tb_pe_mac_dbuf.sv
// Bench for pe_mac_dbuf: a PIPE=0/ACC=16 and a PIPE=1/ACC=20 instance share all inputs.
module tb_pe_mac_dbuf;

  logic        clk;
  logic        rst_n, sgn, sat, clr, w_en, swap, act_en, ps_en;
  logic [7:0]  w_in, act;
  logic [15:0] ps0;
  logic [19:0] ps1;

  logic        w_oen_0, w_ready_0, w_err_0, act_oen_0, ps_oen_0, ovf_0;
  logic [7:0]  w_o_0, act_o_0;
  logic [15:0] ps_o_0;
  logic        w_oen_1, w_ready_1, w_err_1, act_oen_1, ps_oen_1, ovf_1;
  logic [7:0]  w_o_1, act_o_1;
  logic [19:0] ps_o_1;

  int total = 0;
  int bad = 0;

  pe_mac_dbuf #(.DATA_WIDTH(8), .ACC_WIDTH(16), .PIPE(0)) u0 (
    .PE_clk(clk), .PE_rst_n(rst_n), .PE_mode_signed(sgn), .PE_sat_en(sat), .PE_clr(clr),
    .PE_w_en(w_en), .PE_w_in(w_in), .PE_w_swap(swap), .PE_w_out_en(w_oen_0),
    .PE_w_out(w_o_0), .PE_w_ready(w_ready_0), .PE_w_err(w_err_0),
    .PE_act_en(act_en), .PE_act_in(act), .PE_act_out_en(act_oen_0), .PE_act_out(act_o_0),
    .PE_psum_en(ps_en), .PE_psum_in(ps0), .PE_psum_out_en(ps_oen_0), .PE_psum_out(ps_o_0),
    .PE_ovf(ovf_0)
  );

  pe_mac_dbuf #(.DATA_WIDTH(8), .ACC_WIDTH(20), .PIPE(1)) u1 (
    .PE_clk(clk), .PE_rst_n(rst_n), .PE_mode_signed(sgn), .PE_sat_en(sat), .PE_clr(clr),
    .PE_w_en(w_en), .PE_w_in(w_in), .PE_w_swap(swap), .PE_w_out_en(w_oen_1),
    .PE_w_out(w_o_1), .PE_w_ready(w_ready_1), .PE_w_err(w_err_1),
    .PE_act_en(act_en), .PE_act_in(act), .PE_act_out_en(act_oen_1), .PE_act_out(act_o_1),
    .PE_psum_en(ps_en), .PE_psum_in(ps1), .PE_psum_out_en(ps_oen_1), .PE_psum_out(ps_o_1),
    .PE_ovf(ovf_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  m_shadow, m_active, m_wout, m_act;
  logic        m_ready, m_err, m_wout_en, m_act_en;
  logic [15:0] m_ps0;
  logic        m_ps0_en, m_ovf0;
  logic [19:0] m_ps1, p_val;
  logic        m_ps1_en, m_ovf1, p_valid, p_ovf;

  logic [19:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Exact-integer MAC: result range check decides overflow, then clamp or wrap.
  function automatic void mac_ref(input int acc_w, input logic sg, input logic st,
                                  input logic [7:0] a, input logic [7:0] w, input logic pe,
                                  input logic [19:0] ps, output logic [19:0] val,
                                  output logic ov);
    longint av, wv, pv, s, half, full, lo, hi;
    logic [63:0] t;
    half = longint'(1) <<< (acc_w - 1);
    full = half * 2;
    pv = longint'(ps);
    if (sg) begin
      av = longint'($signed(a));
      wv = longint'($signed(w));
      if (pv >= half) pv = pv - full;
      lo = -half;
      hi = half - 1;
    end else begin
      av = longint'(a);
      wv = longint'(w);
      lo = 0;
      hi = full - 1;
    end
    s = av * wv + (pe ? pv : longint'(0));
    ov = (s < lo) || (s > hi);
    if (ov && st) s = (s > hi) ? hi : lo;
    t = 64'(s) & 64'(full - 1);
    val = t[19:0];
  endfunction

  task automatic model_edge();
    logic [19:0] v0, v1;
    logic        o0, o1;
    logic [7:0]  old_sh;
    if (!rst_n) begin
      m_shadow = 0; m_active = 0; m_wout = 0; m_act = 0;
      m_ready = 0; m_err = 0; m_wout_en = 0; m_act_en = 0;
      m_ps0 = 0; m_ps0_en = 0; m_ovf0 = 0;
      m_ps1 = 0; m_ps1_en = 0; m_ovf1 = 0;
      p_valid = 0; p_val = 0; p_ovf = 0;
    end else begin
      mac_ref(16, sgn, sat, act, m_active, ps_en, {4'b0, ps0}, v0, o0);
      mac_ref(20, sgn, sat, act, m_active, ps_en, ps1, v1, o1);
      m_ps0_en = act_en;
      if (act_en) m_ps0 = v0[15:0];
      if (act_en && o0) m_ovf0 = 1;
      else if (clr) m_ovf0 = 0;
      m_ps1_en = p_valid;
      if (p_valid) m_ps1 = p_val;
      if (p_valid && p_ovf) m_ovf1 = 1;
      else if (clr) m_ovf1 = 0;
      p_valid = act_en; p_val = v1; p_ovf = o1;
      old_sh = m_shadow;
      m_err = 0;
      if (swap) begin
        if (m_ready) m_active = old_sh;
        else m_err = 1;
      end
      m_wout_en = w_en;
      if (w_en) begin
        m_wout = old_sh;
        m_shadow = w_in;
      end
      m_ready = w_en ? 1'b1 : (swap ? 1'b0 : m_ready);
      m_act_en = act_en;
      if (act_en) m_act = act;
    end
  endtask

  task automatic check_all();
    chk("u0_w_out_en", w_oen_0, m_wout_en);   chk("u1_w_out_en", w_oen_1, m_wout_en);
    chk("u0_w_out", w_o_0, m_wout);            chk("u1_w_out", w_o_1, m_wout);
    chk("u0_w_ready", w_ready_0, m_ready);     chk("u1_w_ready", w_ready_1, m_ready);
    chk("u0_w_err", w_err_0, m_err);           chk("u1_w_err", w_err_1, m_err);
    chk("u0_act_en", act_oen_0, m_act_en);     chk("u1_act_en", act_oen_1, m_act_en);
    chk("u0_act", act_o_0, m_act);             chk("u1_act", act_o_1, m_act);
    chk("u0_psum_en", ps_oen_0, m_ps0_en);     chk("u1_psum_en", ps_oen_1, m_ps1_en);
    chk("u0_psum", ps_o_0, m_ps0);             chk("u1_psum", ps_o_1, m_ps1);
    chk("u0_ovf", ovf_0, m_ovf0);              chk("u1_ovf", ovf_1, m_ovf1);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst_n = 1; sgn = 0; sat = 0; clr = 0; w_en = 0; w_in = 0; swap = 0;
    act_en = 0; act = 0; ps_en = 0; ps0 = 0; ps1 = 0;
  endtask

  typedef struct {
    logic        rst_n, sgn, sat, clr, w_en;
    logic [7:0]  w_in;
    logic        swap, act_en;
    logic [7:0]  act;
    logic        ps_en;
    logic [15:0] ps;
    logic        e_ps_en;
    logic [15:0] e_ps;
    logic        e_ready, e_err, e_ovf, e_wout_en;
    logic [7:0]  e_wout;
  } vec_t;

  localparam int NV = 27;
  vec_t vt[NV];

  initial begin
    int n, first, early, late;
    logic [19:0] e;
    idle();
    rst_n = 0;

    // rst sgn sat clr w_en w_in swap act_en act ps_en ps | ps_en ps ready err ovf wout_en wout
    vt[0]  = '{0,1,1,1,1,8'hAA,1,1,8'h55,1,16'h1234, 0,16'h0000,0,0,0,0,8'h00};
    vt[1]  = '{0,0,0,0,1,8'h55,0,1,8'hAA,1,16'h4321, 0,16'h0000,0,0,0,0,8'h00};
    vt[2]  = '{1,0,0,0,1,8'd3,0,0,8'd0,0,16'd0,      0,16'd0,1,0,0,1,8'd0};
    vt[3]  = '{1,0,0,0,0,8'd0,1,0,8'd0,0,16'd0,      0,16'd0,0,0,0,0,8'd0};
    vt[4]  = '{1,0,0,0,0,8'd0,0,1,8'd5,1,16'd10,     1,16'd25,0,0,0,0,8'd0};
    vt[5]  = '{1,0,0,0,1,8'd2,0,0,8'd0,0,16'd0,      0,16'd25,1,0,0,1,8'd3};
    vt[6]  = '{1,0,0,0,0,8'd0,1,0,8'd0,0,16'd0,      0,16'd25,0,0,0,0,8'd3};
    vt[7]  = '{1,0,0,0,1,8'd7,0,0,8'd0,0,16'd0,      0,16'd25,1,0,0,1,8'd2};
    vt[8]  = '{1,0,0,0,0,8'd0,1,1,8'd4,0,16'd0,      1,16'd8,0,0,0,0,8'd2};
    vt[9]  = '{1,0,0,0,0,8'd0,0,1,8'd4,0,16'd0,      1,16'd28,0,0,0,0,8'd2};
    vt[10] = '{1,0,0,0,0,8'd0,1,0,8'd0,0,16'd0,      0,16'd28,0,1,0,0,8'd2};
    vt[11] = '{1,0,0,0,0,8'd0,0,1,8'd4,0,16'd0,      1,16'd28,0,0,0,0,8'd2};
    vt[12] = '{1,1,0,0,1,8'h80,0,0,8'd0,0,16'd0,     0,16'd28,1,0,0,1,8'd7};
    vt[13] = '{1,1,0,0,0,8'd0,1,0,8'd0,0,16'd0,      0,16'd28,0,0,0,0,8'd7};
    vt[14] = '{1,1,0,0,0,8'd0,0,1,8'h80,1,16'd0,     1,16'h4000,0,0,0,0,8'd7};
    vt[15] = '{1,1,0,0,1,8'd5,0,0,8'd0,0,16'd0,      0,16'h4000,1,0,0,1,8'h80};
    vt[16] = '{1,1,0,0,0,8'd0,1,0,8'd0,0,16'd0,      0,16'h4000,0,0,0,0,8'h80};
    vt[17] = '{1,1,0,0,0,8'd0,0,1,8'hFD,1,16'd2,     1,16'hFFF3,0,0,0,0,8'h80};
    vt[18] = '{1,1,0,0,1,8'd1,0,0,8'd0,0,16'd0,      0,16'hFFF3,1,0,0,1,8'd5};
    vt[19] = '{1,1,0,0,0,8'd0,1,0,8'd0,0,16'd0,      0,16'hFFF3,0,0,0,0,8'd5};
    vt[20] = '{1,1,1,0,0,8'd0,0,1,8'd10,1,16'h7FF8,  1,16'h7FFF,0,0,1,0,8'd5};
    vt[21] = '{1,1,0,0,0,8'd0,0,1,8'd10,1,16'h7FF8,  1,16'h8002,0,0,1,0,8'd5};
    vt[22] = '{1,1,0,1,0,8'd0,0,0,8'd0,0,16'd0,      0,16'h8002,0,0,0,0,8'd5};
    vt[23] = '{1,1,0,1,0,8'd0,0,1,8'd10,1,16'h7FF8,  1,16'h8002,0,0,1,0,8'd5};
    vt[24] = '{1,0,1,0,0,8'd0,0,1,8'd10,1,16'hFFF8,  1,16'hFFFF,0,0,1,0,8'd5};
    vt[25] = '{1,0,1,1,0,8'd0,0,0,8'd0,0,16'd0,      0,16'hFFFF,0,0,0,0,8'd5};
    vt[26] = '{1,0,1,0,0,8'd0,0,1,8'd7,1,16'hFFF8,   1,16'hFFFF,0,0,0,0,8'd5};

    for (int i = 0; i < NV; i++) begin
      rst_n = vt[i].rst_n; sgn = vt[i].sgn; sat = vt[i].sat; clr = vt[i].clr;
      w_en = vt[i].w_en; w_in = vt[i].w_in; swap = vt[i].swap;
      act_en = vt[i].act_en; act = vt[i].act; ps_en = vt[i].ps_en; ps0 = vt[i].ps;
      ps1 = vt[i].sgn ? 20'($signed(vt[i].ps)) : 20'(vt[i].ps);
      step();
      chk($sformatf("tbl%0d_psum_en", i), ps_oen_0, vt[i].e_ps_en);
      chk($sformatf("tbl%0d_psum", i), ps_o_0, vt[i].e_ps);
      chk($sformatf("tbl%0d_w_ready", i), w_ready_0, vt[i].e_ready);
      chk($sformatf("tbl%0d_w_err", i), w_err_0, vt[i].e_err);
      chk($sformatf("tbl%0d_ovf", i), ovf_0, vt[i].e_ovf);
      chk($sformatf("tbl%0d_w_out_en", i), w_oen_0, vt[i].e_wout_en);
      chk($sformatf("tbl%0d_w_out", i), w_o_0, vt[i].e_wout);
    end

    // back-to-back issue on the pipelined instance: weight 3, acts 1..8
    idle(); w_en = 1; w_in = 8'd3; step();
    idle(); swap = 1; step();
    exp_q.delete();
    for (int k = 1; k <= 8; k++) begin
      e = 20'(3 * k);
      exp_q.push_back(e);
    end
    n = 0;
    first = -1;
    for (int c = 0; c < 11; c++) begin
      idle();
      if (c < 8) begin
        act_en = 1;
        act = 8'(c + 1);
      end
      step();
      if (ps_oen_1) begin
        if (first < 0) first = c;
        n++;
        if (exp_q.size() > 0) chk("b2b_value", ps_o_1, exp_q.pop_front());
      end
    end
    chk("b2b_count", n, 8);
    chk("b2b_first_edge", first, 1);

    // reset held from issue cycle 4 discards everything in flight
    early = 0;
    late = 0;
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c < 8) begin
        act_en = 1;
        act = 8'(c + 1);
      end
      if (c >= 4 && c < 8) rst_n = 0;
      step();
      if (ps_oen_1) begin
        if (c < 4) early++;
        else late++;
      end
    end
    chk("rst_early_pulses", early, 3);
    chk("rst_late_pulses", late, 0);

    // randomized traffic against the model, one batch per mode/saturation combination
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 150; i++) begin
        sgn    = b[0];
        sat    = b[1];
        rst_n  = ($urandom_range(0, 99) != 0);
        w_en   = ($urandom_range(0, 2) == 0);
        w_in   = 8'($urandom);
        swap   = ($urandom_range(0, 3) == 0);
        act_en = 1'($urandom_range(0, 1));
        act    = 8'($urandom);
        ps_en  = 1'($urandom_range(0, 1));
        ps0    = 16'($urandom);
        ps1    = 20'($urandom);
        clr    = ($urandom_range(0, 7) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
